bitplane_sequencer: RTL

- Parametrised successor to the single-channel plane synchronizer.
- Arms on a serial-ready edge and aligns to the next vsync.
- Then emits one delayed, width-controlled send pulse per incoming bitplane strobe, for a runtime-configurable number of planes.
- Adds input resynchronisation, per-plane delay, continuous-frame mode, watchdog timeout, abort and status reporting; sits between the DMD/projector timing inputs and the camera/acquisition trigger.

---
 rtl/bitplane_seq_pkg.sv | 25 ++
 rtl/bitplane_sequencer_edge_sync.sv | 27 ++
 rtl/bitplane_sequencer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/bitplane_seq_pkg.sv
// Shared types and default sizing for the bitplane sequencer.
package bitplane_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_VSYNC,
    WAIT_PLANE,
    DELAY,
    PULSE,
    DONE
  } seq_state_t;

  localparam int unsigned DEF_MAX_PLANES  = 24;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_DELAY_W     = 16;
  localparam int unsigned DEF_PULSE_W     = 4;
  localparam int unsigned DEF_TIMEOUT     = 1000000;
  localparam int unsigned DEF_FRAME_W     = 16;

  // Width needed to hold a plane count of 0..max_planes inclusive.
  function automatic int unsigned plane_width(input int unsigned max_planes);
    return $clog2(max_planes + 1);
  endfunction

endpackage

// File: rtl/bitplane_sequencer_edge_sync.sv
// Multi-stage synchronizer for an asynchronous input plus a registered
// one-cycle rising-edge strobe (edge to strobe latency SYNC_STAGES+1).
module edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      hist_q <= sync_q[SYNC_STAGES-1];
      rise   <= sync_q[SYNC_STAGES-1] & ~hist_q;
    end
  end

endmodule

// File: rtl/bitplane_sequencer.sv
// Arms on serial, aligns to vsync, then emits one delayed send pulse per
// bitplane strobe for a configured number of planes per frame.
module bitplane_sequencer
  import bitplane_seq_pkg::*;
#(
  parameter  int unsigned MAX_PLANES  = DEF_MAX_PLANES,
  parameter  int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter  int unsigned DELAY_W     = DEF_DELAY_W,
  parameter  int unsigned PULSE_W     = DEF_PULSE_W,
  parameter  int unsigned TIMEOUT     = DEF_TIMEOUT,
  parameter  int unsigned FRAME_W     = DEF_FRAME_W,
  localparam int unsigned PLANE_W     = plane_width(MAX_PLANES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vsync,
  input  logic               serial,
  input  logic               bitplane,
  input  logic               abort,
  input  logic               continuous,
  input  logic [PLANE_W-1:0] n_planes,
  input  logic [DELAY_W-1:0] delay_cfg,
  output logic               send,
  output logic               busy,
  output logic [PLANE_W-1:0] plane_idx,
  output logic [FRAME_W-1:0] frame_count,
  output logic               done,
  output logic               timeout_err,
  output logic               overrun,
  output logic               cfg_err
);

  localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned PC_W = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
  localparam logic [WD_W-1:0]    WD_LAST = (TIMEOUT == 0) ? '0 : WD_W'(TIMEOUT - 1);
  localparam logic [PC_W-1:0]    PC_LAST = PC_W'(PULSE_W - 1);
  localparam logic [PLANE_W-1:0] MAXP    = PLANE_W'(MAX_PLANES);

  logic vsync_rise, serial_rise, bitplane_rise;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_vsync (
    .clk(clk), .rst(rst), .din(vsync), .rise(vsync_rise));
  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_serial (
    .clk(clk), .rst(rst), .din(serial), .rise(serial_rise));
  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bitplane (
    .clk(clk), .rst(rst), .din(bitplane), .rise(bitplane_rise));

  seq_state_t         state_q, state_d;
  logic [PLANE_W-1:0] np_q, np_d, pidx_d;
  logic [DELAY_W-1:0] dcfg_q, dcfg_d, dly_q, dly_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [FRAME_W-1:0] frame_d;
  logic               done_d, to_d, ovr_d, cfg_d;

  always_comb begin
    state_d = state_q;
    np_d    = np_q;
    dcfg_d  = dcfg_q;
    dly_d   = dly_q;
    pc_d    = pc_q;
    wd_d    = wd_q;
    pidx_d  = plane_idx;
    frame_d = frame_count;
    done_d  = 1'b0;
    to_d    = 1'b0;
    ovr_d   = 1'b0;
    cfg_d   = 1'b0;

    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (serial_rise) begin
            if (n_planes == '0 || n_planes > MAXP) begin
              cfg_d = 1'b1;
            end else begin
              state_d = WAIT_VSYNC;
              np_d    = n_planes;
              dcfg_d  = delay_cfg;
              pidx_d  = '0;
            end
          end
        end
        WAIT_VSYNC: begin
          if (vsync_rise) begin
            state_d = WAIT_PLANE;
            pidx_d  = '0;
            wd_d    = '0;
          end
        end
        WAIT_PLANE: begin
          // A plane edge landing on the final watchdog cycle still wins.
          if (bitplane_rise) begin
            pc_d = '0;
            if (dcfg_q == '0) begin
              state_d = PULSE;
            end else begin
              state_d = DELAY;
              dly_d   = dcfg_q;
            end
          end else if (TIMEOUT != 0 && wd_q == WD_LAST) begin
            to_d    = 1'b1;
            state_d = IDLE;
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end
        DELAY: begin
          ovr_d = bitplane_rise;
          if (dly_q == DELAY_W'(1)) state_d = PULSE;
          else                      dly_d   = dly_q - 1'b1;
        end
        PULSE: begin
          ovr_d = bitplane_rise;
          if (pc_q == PC_LAST) begin
            pidx_d = plane_idx + 1'b1;
            if (pidx_d == np_q) begin
              state_d = DONE;
            end else begin
              state_d = WAIT_PLANE;
              wd_d    = '0;
            end
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
        DONE:    state_d = continuous ? WAIT_VSYNC : IDLE;
        default: state_d = IDLE;
      endcase

      if (state_d == DONE) begin
        done_d  = 1'b1;
        frame_d = frame_count + 1'b1;
      end
    end
  end

  // Outputs are registered from next-state so they line up with the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      np_q        <= '0;
      dcfg_q      <= '0;
      dly_q       <= '0;
      pc_q        <= '0;
      wd_q        <= '0;
      send        <= 1'b0;
      busy        <= 1'b0;
      plane_idx   <= '0;
      frame_count <= '0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      overrun     <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      state_q     <= state_d;
      np_q        <= np_d;
      dcfg_q      <= dcfg_d;
      dly_q       <= dly_d;
      pc_q        <= pc_d;
      wd_q        <= wd_d;
      send        <= (state_d == PULSE);
      busy        <= (state_d != IDLE);
      plane_idx   <= pidx_d;
      frame_count <= frame_d;
      done        <= done_d;
      timeout_err <= to_d;
      overrun     <= ovr_d;
      cfg_err     <= cfg_d;
    end
  end

endmodule
